// File: rtl/logic_chk_pkg.sv
// Shared types, result bit positions and the golden function for the
// 8-in/10-out logic unit checker.
package logic_chk_pkg;

    localparam int VEC_W   = 8;
    localparam int NUM_RES = 10;

    localparam int B1_IDX  = 0;
    localparam int B2_IDX  = 1;
    localparam int B3_IDX  = 2;
    localparam int B4_IDX  = 3;
    localparam int B5_IDX  = 4;
    localparam int B6_IDX  = 5;
    localparam int B7_IDX  = 6;
    localparam int B8_IDX  = 7;
    localparam int B9_IDX  = 8;
    localparam int B10_IDX = 9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Only a=vec[7], b=vec[6], c=vec[5], d=vec[4] feed the results.
    function automatic logic [NUM_RES-1:0] golden(input logic [VEC_W-1:0] vec);
        logic a, b, c, d;
        logic [NUM_RES-1:0] r;
        a = vec[7];
        b = vec[6];
        c = vec[5];
        d = vec[4];
        r          = '0;
        r[B1_IDX]  = a & b;
        r[B2_IDX]  = a | b;
        r[B3_IDX]  = ~(a & b);
        r[B4_IDX]  = ~(a | b);
        r[B5_IDX]  = a ^ b;
        r[B6_IDX]  = ~(a ^ b);
        r[B7_IDX]  = ~a;
        r[B8_IDX]  = a;
        r[B9_IDX]  = (a | b) && (c | d);
        r[B10_IDX] = (a | b) || (c | d);
        return r;
    endfunction

endpackage

// File: rtl/logic_golden.sv
// Combinational reference model of the logic unit: input vector -> expected
// result bits.
module logic_golden
    import logic_chk_pkg::*;
(
    input  logic [VEC_W-1:0]   vec_i,
    output logic [NUM_RES-1:0] exp_o
);

    assign exp_o = golden(vec_i);

endmodule

// File: rtl/logic_result_checker.sv
// Checks a stream of {vector, results} against the golden model through a
// 2-stage pipe, counting checks/errors and capturing the first failure.
module logic_result_checker
    import logic_chk_pkg::*;
#(
    parameter int NUM_VEC = 256,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               vld_i,
    output logic               rdy_o,
    input  logic [VEC_W-1:0]   vec_i,
    input  logic [NUM_RES-1:0] res_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               fail_o,
    output logic [CNT_W-1:0]   chk_cnt_o,
    output logic [CNT_W-1:0]   err_cnt_o,
    output logic [VEC_W-1:0]   first_vec_o,
    output logic [NUM_RES-1:0] first_mask_o
);

    localparam logic [CNT_W-1:0] LAST_ACC = CNT_W'(NUM_VEC - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]     chk_cnt_q, chk_cnt_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 fail_q, fail_d;
    logic [VEC_W-1:0]     first_vec_q, first_vec_d;
    logic [NUM_RES-1:0]   first_mask_q, first_mask_d;

    logic                 s1_vld_q, s2_vld_q;
    logic [VEC_W-1:0]     s1_vec_q, s2_vec_q;
    logic [NUM_RES-1:0]   s1_res_q, s2_mask_q;
    logic [NUM_RES-1:0]   s1_exp;

    logic accept;
    logic run_start;

    assign rdy_o     = (state_q == RUN);
    assign busy_o    = (state_q == RUN) || (state_q == DRAIN);
    assign done_o    = (state_q == DONE);
    assign accept    = vld_i & rdy_o;
    assign run_start = start && ((state_q == IDLE) || (state_q == DONE));

    logic_golden u_golden (
        .vec_i (s1_vec_q),
        .exp_o (s1_exp)
    );

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        acc_cnt_d    = acc_cnt_q;
        chk_cnt_d    = chk_cnt_q;
        err_cnt_d    = err_cnt_q;
        fail_d       = fail_q;
        first_vec_d  = first_vec_q;
        first_mask_d = first_mask_q;

        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (acc_cnt_q == LAST_ACC) state_d = DRAIN;
                end
            end
            // Nothing enters S1 in DRAIN, so S1 empty means both stages are empty next edge.
            DRAIN: if (!s1_vld_q) state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (s2_vld_q) begin
            chk_cnt_d = chk_cnt_q + CNT_W'(1);
            if (|s2_mask_q) begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                if (!fail_q) begin
                    fail_d       = 1'b1;
                    first_vec_d  = s2_vec_q;
                    first_mask_d = s2_mask_q;
                end
            end
        end

        if (run_start) begin
            acc_cnt_d    = '0;
            chk_cnt_d    = '0;
            err_cnt_d    = '0;
            fail_d       = 1'b0;
            first_vec_d  = '0;
            first_mask_d = '0;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_cnt_q    <= '0;
            chk_cnt_q    <= '0;
            err_cnt_q    <= '0;
            fail_q       <= 1'b0;
            first_vec_q  <= '0;
            first_mask_q <= '0;
            s1_vld_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            chk_cnt_q    <= chk_cnt_d;
            err_cnt_q    <= err_cnt_d;
            fail_q       <= fail_d;
            first_vec_q  <= first_vec_d;
            first_mask_q <= first_mask_d;
            s1_vld_q     <= accept;
            s2_vld_q     <= s1_vld_q;
        end
    end

    // NOTE: pipe payload is not reset; it is only ever consumed under its valid bit.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_vec_q <= vec_i;
            s1_res_q <= res_i;
        end
        s2_vec_q  <= s1_vec_q;
        s2_mask_q <= s1_exp ^ s1_res_q;
    end

    assign chk_cnt_o    = chk_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign fail_o       = fail_q;
    assign first_vec_o  = first_vec_q;
    assign first_mask_o = first_mask_q;

endmodule

// File: tb/tb_logic_result_checker.sv
// Directed bench for logic_result_checker: a full-size (256) instance and a
// 4-vector instance share clock, reset and stream inputs.
module tb_logic_result_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b, vld;
    logic [7:0] vec;
    logic [9:0] res;

    logic        rdy_a, busy_a, done_a, fail_a;
    logic [15:0] chk_a, err_a;
    logic [7:0]  fvec_a;
    logic [9:0]  fmask_a;

    logic        rdy_b, busy_b, done_b, fail_b;
    logic [15:0] chk_b, err_b;
    logic [7:0]  fvec_b;
    logic [9:0]  fmask_b;

    int total = 0;
    int bad   = 0;

    logic_result_checker #(.NUM_VEC(256), .CNT_W(16)) dut_a (
        .clk (clk), .rst (rst), .start (start_a), .vld_i (vld), .rdy_o (rdy_a),
        .vec_i (vec), .res_i (res), .busy_o (busy_a), .done_o (done_a), .fail_o (fail_a),
        .chk_cnt_o (chk_a), .err_cnt_o (err_a), .first_vec_o (fvec_a), .first_mask_o (fmask_a)
    );

    logic_result_checker #(.NUM_VEC(4), .CNT_W(16)) dut_b (
        .clk (clk), .rst (rst), .start (start_b), .vld_i (vld), .rdy_o (rdy_b),
        .vec_i (vec), .res_i (res), .busy_o (busy_b), .done_o (done_b), .fail_o (fail_b),
        .chk_cnt_o (chk_b), .err_cnt_o (err_b), .first_vec_o (fvec_b), .first_mask_o (fmask_b)
    );

    // Bit k-1 holds Bk; written as one concatenation from B10 down to B1.
    function automatic logic [9:0] model(input logic [7:0] v);
        logic a, b, c, d;
        a = v[7]; b = v[6]; c = v[5]; d = v[4];
        return {(a | b) | (c | d), (a | b) & (c | d), a, ~a, ~(a ^ b), a ^ b,
                ~(a | b), ~(a & b), a | b, a & b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a();
        for (int k = 0; k < 20 && !done_a; k++) tick();
        check("done_a_timeout", 32'(done_a), 1);
    endtask

    // Streams all 256 vectors into dut_a; fm0/fm1 corrupt the results of bv0/bv1.
    task automatic run_full(input logic [7:0] bv0, input logic [9:0] fm0,
                            input logic [7:0] bv1, input logic [9:0] fm1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("start_chk_clr", 32'(chk_a), 0);
        check("start_fail_clr", 32'(fail_a), 0);
        check("start_rdy", 32'(rdy_a), 1);
        for (int i = 0; i < 256; i++) begin
            vec = 8'(i);
            res = model(vec) ^ ((vec == bv0) ? fm0 : 10'h000) ^ ((vec == bv1) ? fm1 : 10'h000);
            vld = 1'b1;
            tick();
        end
        vld = 1'b0;
        check("rdy_drop_after_last", 32'(rdy_a), 0);
        wait_done_a();
    endtask

    initial begin
        automatic int acc;
        automatic int rdy_low;
        automatic int done_tick;
        automatic bit drain_pulsed;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; vld = 1'b0; vec = '0; res = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_rdy", 32'(rdy_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_fail", 32'(fail_a), 0);
        check("rst_chk", 32'(chk_a), 0);
        check("rst_err", 32'(err_a), 0);
        check("rst_fvec", 32'(fvec_a), 0);
        check("rst_fmask", 32'(fmask_a), 0);

        // Clean pass over all 256 vectors.
        run_full(8'h00, 10'h000, 8'h00, 10'h000);
        check("t1_chk", 32'(chk_a), 256);
        check("t1_err", 32'(err_a), 0);
        check("t1_fail", 32'(fail_a), 0);
        check("t1_busy", 32'(busy_a), 0);

        // B9 flipped on 8'hC0.
        run_full(8'hC0, 10'h100, 8'h00, 10'h000);
        check("t2_chk", 32'(chk_a), 256);
        check("t2_err", 32'(err_a), 1);
        check("t2_fail", 32'(fail_a), 1);
        check("t2_fvec", 32'(fvec_a), 'hC0);
        check("t2_fmask", 32'(fmask_a), 'h100);

        // Two failures; the capture keeps the first.
        run_full(8'h40, 10'h001, 8'h80, 10'h200);
        check("t3_err", 32'(err_a), 2);
        check("t3_fail", 32'(fail_a), 1);
        check("t3_fvec", 32'(fvec_a), 'h40);
        check("t3_fmask", 32'(fmask_a), 'h001);

        // Reset one cycle after three accepts, the first of them corrupt.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vec = 8'(i);
            res = model(vec) ^ ((i == 0) ? 10'h008 : 10'h000);
            vld = 1'b1;
            tick();
        end
        vld = 1'b0;
        tick();
        check("t5_pre_rst_fail", 32'(fail_a), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_rdy", 32'(rdy_a), 0);
        check("t5_rst_busy", 32'(busy_a), 0);
        check("t5_rst_done", 32'(done_a), 0);
        check("t5_rst_fail", 32'(fail_a), 0);
        check("t5_rst_chk", 32'(chk_a), 0);
        check("t5_rst_err", 32'(err_a), 0);
        check("t5_rst_fvec", 32'(fvec_a), 0);
        check("t5_rst_fmask", 32'(fmask_a), 0);

        // Fresh run after reset: two-cycle latency from accept to chk change.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        vec = 8'h55; res = model(vec); vld = 1'b1;
        tick();
        vld = 1'b0;
        check("t5_lat_1", 32'(chk_a), 0);
        tick();
        check("t5_lat_2", 32'(chk_a), 0);
        tick();
        check("t5_lat_3", 32'(chk_a), 1);
        vec = 8'hE7; res = model(vec); vld = 1'b1;
        tick();
        vld = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("t5_chk2", 32'(chk_a), 2);
        check("t5_err0", 32'(err_a), 0);
        check("t5_busy", 32'(busy_a), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // NUM_VEC=4 instance with vld held high for 10 cycles.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        acc = 0; rdy_low = 0; done_tick = 0;
        for (int k = 1; k <= 10; k++) begin
            vec = 8'(k * 37); res = model(vec); vld = 1'b1;
            if (rdy_b) acc++;
            if (!rdy_b && rdy_low == 0) rdy_low = k;
            tick();
            if (done_b && done_tick == 0) done_tick = k;
        end
        vld = 1'b0;
        check("t4_accepts", 32'(acc), 4);
        check("t4_rdy_low_cycle", 32'(rdy_low), 5);
        check("t4_done_by_7", 32'(done_tick != 0 && done_tick <= 7), 1);
        check("t4_chk", 32'(chk_b), 4);
        check("t4_err", 32'(err_b), 0);
        check("t4_done", 32'(done_b), 1);

        // Random gaps; start pulses in RUN and DRAIN must be ignored.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        acc = 0; drain_pulsed = 1'b0;
        for (int k = 0; k < 200 && !done_b; k++) begin
            vld = 1'($urandom_range(0, 1));
            vec = 8'($urandom);
            res = model(vec);
            start_b = 1'b0;
            if (k == 1) begin
                start_b = 1'b1;
            end else if (busy_b && !rdy_b && !drain_pulsed) begin
                start_b = 1'b1;
                drain_pulsed = 1'b1;
            end
            if (vld && rdy_b) acc++;
            tick();
        end
        start_b = 1'b0;
        vld = 1'b0;
        check("t6_done", 32'(done_b), 1);
        check("t6_drain_start_sent", 32'(drain_pulsed), 1);
        check("t6_accepts", 32'(acc), 4);
        check("t6_chk", 32'(chk_b), 4);
        check("t6_err", 32'(err_b), 0);
        check("t6_fail", 32'(fail_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
